forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl_pkg.sv | 27 ++
 rtl/fwd_src_select.sv | 29 ++
 rtl/forward_ctrl.sv | 123 ++++++++++++
 tb/tb_forward_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/forward_ctrl_pkg.sv
// Shared types and constants for the EX-stage forwarding and hazard controller.
package forward_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] FWD_REG   = 2'b00;
  localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_entry;

  localparam stage_entry NOP_ENTRY = '0;

  // A producer only counts if it really writes a non-x0 register the consumer reads.
  function automatic logic entry_hit(input stage_entry e,
                                     input logic [REG_W-1:0] src,
                                     input logic use_src);
    return e.valid && e.regwrite && (e.rd != REG_W'(0)) && (e.rd == src) && use_src;
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Per-operand forwarding select and load-use detection against the EX and MEM entries.
module fwd_src_select
  import forward_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  stage_entry       i_ex,
  input  stage_entry       i_mem,
  output logic [SEL_W-1:0] o_sel_c,
  output logic             o_load_hit_c
);

  logic w_ex_hit;
  logic w_mem_hit;

  // Youngest producer (EX) wins over the older one (MEM).
  always_comb begin
    w_ex_hit     = entry_hit(i_ex, i_src, i_use);
    w_mem_hit    = entry_hit(i_mem, i_src, i_use);
    o_sel_c      = FWD_REG;
    if (w_ex_hit) begin
      o_sel_c = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel_c = FWD_MEMWB;
    end
    o_load_hit_c = w_ex_hit & i_ex.memread;
  end

endmodule

// File: rtl/forward_ctrl.sv
// Pipeline forwarding controller: tracks EX/MEM producers, registers operand selects,
// and raises stall/bubble for load-use hazards and memory back-pressure.
module forward_ctrl
  import forward_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_valid,
  input  logic             mem_busy,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             stall,
  output logic             bubble
);

  stage_entry       r_ex;
  stage_entry       r_mem;
  logic [SEL_W-1:0] r_fwd_a;
  logic [SEL_W-1:0] r_fwd_b;

  stage_entry       w_ex_nxt;
  stage_entry       w_mem_nxt;
  stage_entry       w_id_entry;
  logic [SEL_W-1:0] w_fwd_a_nxt;
  logic [SEL_W-1:0] w_fwd_b_nxt;
  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_load_hit_a;
  logic             w_load_hit_b;
  logic             w_load_use;

  // An invalid ID slot must never look like it reads anything.
  logic w_use_rs1;
  logic w_use_rs2;
  assign w_use_rs1 = id_use_rs1 & id_valid;
  assign w_use_rs2 = id_use_rs2 & id_valid;

  fwd_src_select u_sel_a (
    .i_src        (id_rs1),
    .i_use        (w_use_rs1),
    .i_ex         (r_ex),
    .i_mem        (r_mem),
    .o_sel_c      (w_sel_a),
    .o_load_hit_c (w_load_hit_a)
  );

  fwd_src_select u_sel_b (
    .i_src        (id_rs2),
    .i_use        (w_use_rs2),
    .i_ex         (r_ex),
    .i_mem        (r_mem),
    .o_sel_c      (w_sel_b),
    .o_load_hit_c (w_load_hit_b)
  );

  assign w_load_use = w_load_hit_a | w_load_hit_b;

  always_comb begin
    w_id_entry = id_valid ? stage_entry'{valid: 1'b1, rd: id_rd,
                                         regwrite: id_regwrite, memread: id_memread}
                          : NOP_ENTRY;
  end

  // Next-state and hazard outputs; mem_busy freezes everything, flush beats load-use.
  always_comb begin
    w_ex_nxt    = r_ex;
    w_mem_nxt   = r_mem;
    w_fwd_a_nxt = r_fwd_a;
    w_fwd_b_nxt = r_fwd_b;
    stall       = 1'b0;
    bubble      = 1'b0;
    if (mem_busy) begin
      stall = 1'b1;
    end else begin
      w_mem_nxt = r_ex;
      if (flush) begin
        w_ex_nxt    = NOP_ENTRY;
        w_fwd_a_nxt = FWD_REG;
        w_fwd_b_nxt = FWD_REG;
      end else if (w_load_use) begin
        w_ex_nxt    = NOP_ENTRY;
        w_fwd_a_nxt = FWD_REG;
        w_fwd_b_nxt = FWD_REG;
        stall       = 1'b1;
        bubble      = 1'b1;
      end else begin
        w_ex_nxt    = w_id_entry;
        w_fwd_a_nxt = w_sel_a;
        w_fwd_b_nxt = w_sel_b;
      end
    end
    if (!reset_n) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex    <= NOP_ENTRY;
      r_mem   <= NOP_ENTRY;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_ex    <= w_ex_nxt;
      r_mem   <= w_mem_nxt;
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;

endmodule

// File: tb/tb_forward_ctrl.sv
// Table-driven bench for forward_ctrl; expected selects queued at drive time, popped after the edge.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_valid;
  logic       mem_busy, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, bubble;

  forward_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_valid    (id_valid),
    .mem_busy    (mem_busy),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .bubble      (bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       v;
    logic       busy;
    logic       fl;
    logic       es;
    logic       eb;
    logic [1:0] ea;
    logic [1:0] ebs;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         n_err = 0;
  int         n_chk = 0;

  function automatic vec_t mk(string name, int rs1, bit u1, int rs2, bit u2, int rd,
                              bit rw, bit mr, bit v, bit busy, bit fl,
                              bit es, bit eb, logic [1:0] ea, logic [1:0] ebs);
    vec_t t;
    t.name = name; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
    t.rd = 5'(rd); t.rw = rw; t.mr = mr; t.v = v; t.busy = busy; t.fl = fl;
    t.es = es; t.eb = eb; t.ea = ea; t.ebs = ebs;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd; id_regwrite = t.rw; id_memread = t.mr; id_valid = t.v;
    mem_busy = t.busy; flush = t.fl;
  endtask

  task automatic check_sels(input string nm);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s.queue: got empty want entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".a"}, fwd_a_sel, e[3:2]);
      chk({nm, ".b"}, fwd_b_sel, e[1:0]);
    end
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk({t.name, ".stall"},  {1'b0, stall},  {1'b0, t.es});
    chk({t.name, ".bubble"}, {1'b0, bubble}, {1'b0, t.eb});
    exp_q.push_back({t.ea, t.ebs});
    @(posedge clk);
    #1;
    check_sels(t.name);
  endtask

  initial begin
    // Consumer reads program order; each row is one ID cycle, expected selects land after the edge.
    vecs.push_back(mk("add_x5",      1,1,  2,1,  5,1,0,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("exfwd_a",     5,1,  1,1,  6,1,0,1, 0,0, 0,0, 2'b01,2'b00));
    vecs.push_back(mk("add_x5b",     1,1,  2,1,  5,1,0,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("unrelated",   1,1,  2,1,  8,1,0,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("memfwd_b",    1,1,  5,1,  7,1,0,1, 0,0, 0,0, 2'b00,2'b10));
    vecs.push_back(mk("add_x7",      1,1,  1,1,  7,1,0,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("youngest",    7,1,  3,1, 10,1,0,1, 0,0, 0,0, 2'b01,2'b00));
    vecs.push_back(mk("lw_x5",       1,1,  0,0,  5,1,1,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("loaduse",     5,1,  5,1,  6,1,0,1, 0,0, 1,1, 2'b00,2'b00));
    vecs.push_back(mk("after_lu",    5,1,  5,1,  6,1,0,1, 0,0, 0,0, 2'b10,2'b10));
    vecs.push_back(mk("lw_x0",       1,1,  0,0,  0,1,1,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("use_x0",      0,1,  0,1, 11,1,0,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("id_invalid", 11,1, 11,1, 13,1,1,0, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("after_nop",  13,1, 11,1, 12,1,0,1, 0,0, 0,0, 2'b00,2'b10));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("busy_hold", 12,1,  1,1, 14,1,0,1, 1,0, 1,0, 2'b00,2'b10));
    vecs.push_back(mk("busy_resume",12,1,  1,1, 14,1,0,1, 0,0, 0,0, 2'b01,2'b00));
    vecs.push_back(mk("lw_x15",      1,1,  0,0, 15,1,1,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("busy_lu",    15,1, 14,1, 16,1,0,1, 1,0, 1,0, 2'b00,2'b00));
    vecs.push_back(mk("lu_post_busy",15,1,14,1, 16,1,0,1, 0,0, 1,1, 2'b00,2'b00));
    vecs.push_back(mk("lu_done",    15,1, 14,1, 16,1,0,1, 0,0, 0,0, 2'b10,2'b00));
    vecs.push_back(mk("lw_x17",      1,1,  0,0, 17,1,1,1, 0,0, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("flush_lu",   17,1, 16,1, 18,1,0,1, 0,1, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("post_flush", 17,1, 17,1, 19,1,0,1, 0,0, 0,0, 2'b10,2'b10));
    vecs.push_back(mk("flush_fwd",  19,1,  1,1, 20,1,0,1, 0,1, 0,0, 2'b00,2'b00));
    vecs.push_back(mk("post_flush2",19,1, 20,1, 21,1,0,1, 0,0, 0,0, 2'b10,2'b00));
    vecs.push_back(mk("pre_rst",    21,1,  0,0, 22,1,1,1, 0,0, 0,0, 2'b01,2'b00));

    // Reset with mem_busy high: outputs must still read cleared.
    reset_n = 1'b0;
    drive(mk("idle", 0,0, 0,0, 0,0,0,0, 1,0, 0,0, 2'b00,2'b00));
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall",  {1'b0, stall},  2'b00);
    chk("rst.bubble", {1'b0, bubble}, 2'b00);
    chk("rst.a", fwd_a_sel, 2'b00);
    chk("rst.b", fwd_b_sel, 2'b00);
    @(negedge clk);
    mem_busy = 1'b0;
    reset_n  = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulsed in the middle of a load-use stall.
    @(negedge clk);
    drive(mk("rst_mid", 22,1, 1,1, 23,1,0,1, 0,0, 1,1, 2'b00,2'b00));
    #1;
    chk("rst_mid.stall",  {1'b0, stall},  2'b01);
    chk("rst_mid.bubble", {1'b0, bubble}, 2'b01);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid.stall_clr",  {1'b0, stall},  2'b00);
    chk("rst_mid.bubble_clr", {1'b0, bubble}, 2'b00);
    chk("rst_mid.a_clr", fwd_a_sel, 2'b00);
    chk("rst_mid.b_clr", fwd_b_sel, 2'b00);
    #1 reset_n = 1'b1;
    exp_q.push_back(4'b0000);
    @(posedge clk);
    #1;
    check_sels("rst_accept");
    apply(mk("after_rst", 23,1, 1,1, 24,1,0,1, 0,0, 0,0, 2'b01,2'b00));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
